// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// op encodings, FSM state values and the default operand width.
package ex_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// WIDTH+1-bit add/subtract unit shared by the multiply and divide loops.
// With sub set it computes a - b; carry = 1 then means a >= b (no borrow).
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           carry
);

  logic [WIDTH:0] b_eff_s;

  // Two's-complement subtract: invert b and inject sub as the carry-in.
  always_comb begin
    if (sub) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    {carry, sum} = {1'b0, a} + {1'b0, b_eff_s} + {{(WIDTH + 1){1'b0}}, sub};
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer producing a HI/LO result after WIDTH+2 cycles.
// Build option MULDIV_SIGNED_EN enables signed MULT/DIV; otherwise every op is unsigned.
module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t           state_r;
  logic             is_div_r, signed_r, sign_a_r, sign_b_r;
  logic [5:0]       count_r;
  logic [WIDTH-1:0] acc_r, mq_r, opb_r, hi_r, lo_r;
  logic             busy_r, done_r, dbz_r;

  logic             signed_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s, fix_hi_s, fix_lo_s;
  logic [WIDTH:0]   as_a_s, as_b_s, as_sum_s;
  logic             as_sub_s, as_carry_s;

  // Decode signedness of the incoming op and form operand magnitudes.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    signed_s = ~op[0];
`else
    signed_s = op[0] & 1'b0;
`endif
    if (signed_s && src_a[WIDTH-1]) begin
      abs_a_s = -src_a;
    end else begin
      abs_a_s = src_a;
    end
    if (signed_s && src_b[WIDTH-1]) begin
      abs_b_s = -src_b;
    end else begin
      abs_b_s = src_b;
    end
  end

  // Steer the shared adder: divide trial-subtracts from the left-shifted remainder.
  always_comb begin
    if (is_div_r) begin
      as_a_s   = {acc_r, mq_r[WIDTH-1]};
      as_b_s   = {1'b0, opb_r};
      as_sub_s = 1'b1;
    end else begin
      as_a_s = {1'b0, acc_r};
      if (mq_r[0]) begin
        as_b_s = {1'b0, opb_r};
      end else begin
        as_b_s = {(WIDTH + 1){1'b0}};
      end
      as_sub_s = 1'b0;
    end
  end

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (as_a_s),
    .b     (as_b_s),
    .sub   (as_sub_s),
    .sum   (as_sum_s),
    .carry (as_carry_s)
  );

  // Sign correction applied in FIX; the remainder follows the dividend's sign.
  always_comb begin
    fix_hi_s = acc_r;
    fix_lo_s = mq_r;
    if (is_div_r) begin
      if (signed_r && (sign_a_r ^ sign_b_r)) begin
        fix_lo_s = -mq_r;
      end else begin
        fix_lo_s = mq_r;
      end
      if (signed_r && sign_a_r) begin
        fix_hi_s = -acc_r;
      end else begin
        fix_hi_s = acc_r;
      end
    end else begin
      if (signed_r && (sign_a_r ^ sign_b_r)) begin
        {fix_hi_s, fix_lo_s} = -{acc_r, mq_r};
      end else begin
        {fix_hi_s, fix_lo_s} = {acc_r, mq_r};
      end
    end
  end

  // Sequencer FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      is_div_r <= 1'b0;
      signed_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      count_r  <= 6'd0;
      acc_r    <= {WIDTH{1'b0}};
      mq_r     <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            is_div_r <= op[1];
            signed_r <= signed_s;
            sign_a_r <= signed_s & src_a[WIDTH-1];
            sign_b_r <= signed_s & src_b[WIDTH-1];
            count_r  <= 6'd0;
            acc_r    <= {WIDTH{1'b0}};
            if (op[1] && (src_b == {WIDTH{1'b0}})) begin
              hi_r    <= src_a;
              lo_r    <= {WIDTH{1'b1}};
              dbz_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              dbz_r   <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= ST_CALC;
              if (op[1]) begin
                mq_r  <= abs_a_s;
                opb_r <= abs_b_s;
              end else begin
                mq_r  <= abs_b_s;
                opb_r <= abs_a_s;
              end
            end
          end
        end
        ST_CALC: begin
          count_r <= count_r + 6'd1;
          if (is_div_r) begin
            if (as_carry_s) begin
              acc_r <= as_sum_s[WIDTH-1:0];
              mq_r  <= {mq_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_r <= as_a_s[WIDTH-1:0];
              mq_r  <= {mq_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_r <= as_sum_s[WIDTH:1];
            mq_r  <= {as_sum_s[0], mq_r[WIDTH-1:1]};
          end
          if (count_r == 6'(WIDTH - 1)) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign div_by_zero = dbz_r;
  assign stall_req   = (start && (state_r == ST_IDLE)) || busy_r;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq; expectations follow MULDIV_SIGNED_EN.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int total;
  int bad;
  int cyc;
  int pulses;

  ex_muldiv_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .stall_req   (stall_req),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // Present a request before edge E0; afterwards cyc = 1 is the cycle after E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    check_eq("stall_on_start", {63'd0, stall_req}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
    while (done !== 1'b1 && cyc < 100) step();
    check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    check_eq({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    check_eq({tag, "_stall_in_done"}, {62'd0, stall_req, busy}, 64'd0);
    step();
    check_eq({tag, "_done_drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {busy, stall_req, done, div_by_zero, hi, lo}, 68'd0);
    reset = 1'b1;
    step();

    // MULTU all-ones squared, also checks busy during CALC.
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("busy_in_calc", {62'd0, busy, stall_req}, 64'd3);
    wait_done("multu_ff", 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    launch(2'b00, 32'hFFFF_FFF9, 32'd3);
`ifdef MULDIV_SIGNED_EN
    wait_done("mult_m7x3", 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
`else
    wait_done("mult_m7x3", 34, 32'h0000_0002, 32'hFFFF_FFEB, 1'b0);
`endif

    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_SIGNED_EN
    wait_done("div_m7d2", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
`else
    wait_done("div_m7d2", 34, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
`endif

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
    wait_done("div_min_m1", 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
`else
    wait_done("div_min_m1", 34, 32'h8000_0000, 32'h0000_0000, 1'b0);
`endif

    launch(2'b11, 32'd5, 32'd0);
    wait_done("divu_5d0", 1, 32'd5, 32'hFFFF_FFFF, 1'b1);

    // The next accepted start clears div_by_zero.
    launch(2'b11, 32'd100, 32'd7);
    check_eq("dbz_clear_on_start", {63'd0, div_by_zero}, 64'd0);
    wait_done("divu_100d7", 34, 32'd2, 32'd14, 1'b0);

    // A start pulsed mid-CALC must be ignored.
    launch(2'b01, 32'd1000, 32'd3);
    repeat (9) step();
    start = 1'b1;
    op    = 2'b11;
    src_a = 32'd9;
    src_b = 32'd0;
    step();
    start = 1'b0;
    wait_done("ignored_start", 34, 32'd0, 32'd3000, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) pulses = pulses + 1;
    end
    check_eq("no_extra_done", 64'(pulses), 64'd0);

    // Reset in the middle of CALC aborts the operation.
    launch(2'b01, 32'hFFFF_FFFF, 32'd2);
    repeat (19) step();
    reset = 1'b0;
    step();
    check_eq("abort_outputs", {busy, stall_req, done, div_by_zero, hi, lo}, 68'd0);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) pulses = pulses + 1;
    end
    check_eq("abort_no_done", 64'(pulses), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer for the execute stage. Accepts one MULT/MULTU/DIV/DIVU request from the ID/EX control path and runs a shared 33-bit add/subtract-and-shift loop for WIDTH cycles. It holds the pipeline via a stall request while busy and publishes a 64-bit HI/LO result that sits beside the single-cycle ALU path feeding the EX/MEM register.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend (rdata1out)
- src_b  in  WIDTH  multiplier / divisor (rdata2out)
- busy  out  1  operation in progress (CALC or FIX)
- stall_req  out  1  combinational: (start & IDLE) | busy; freezes IF/ID/EX
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  WIDTH  product high word / remainder
- lo  out  WIDTH  product low word / quotient
- div_by_zero  out  1  set with done when a DIV/DIVU had src_b == 0

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on start, latch op and operand magnitudes (signed ops: two's-complement absolute value), record sign_a, sign_b; clear 6-bit count and accumulator.
  - If op is DIV/DIVU and src_b == 0, go straight to DONE with hi = src_a, lo = all ones, div_by_zero = 1.
  - Otherwise go to CALC.
- CALC, multiply: if multiplier LSB = 1, add multiplicand into the upper half (33-bit sum keeps the carry). Then shift {acc, multiplier} right by 1.
- CALC, divide (restoring): shift {rem, quo} left by 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB.
- CALC: count increments each cycle. Go to FIX when count == WIDTH-1.
- FIX: signed multiply negates the 64-bit product if sign_a ^ sign_b. Signed divide negates the quotient if sign_a ^ sign_b, and negates the remainder if sign_a. Unsigned ops pass through. Always goes to DONE.
- DONE: done = 1 for one cycle, hi/lo updated, then IDLE.
- hi, lo, div_by_zero hold until the next DONE. div_by_zero clears on the next accepted start.
- start while busy or in DONE is ignored; no queueing.
- -2^31 / -1 (signed) yields lo = 0x80000000, hi = 0, with no exception.

## Timing
- Reset values:
  - state IDLE
  - busy 0, done 0, div_by_zero 0
  - hi 0, lo 0
  - count 0
- Normal latency: start sampled at edge E0. CALC runs edges E1..E(WIDTH), FIX at E(WIDTH+1). done is high in the cycle after E(WIDTH+1); hi/lo are valid from the same edge. Total WIDTH+2 cycles from the start edge to done.
- Divide-by-zero latency: done is high in the cycle after E0 (1 cycle).
- stall_req is high from the start cycle until the last CALC/FIX cycle and low during DONE. The pipeline advances on the done cycle and captures hi/lo.
- Reset asserted mid-operation aborts at the next edge: all outputs return to reset values, and no done pulse is produced.

## Configuration
- MULDIV_SIGNED_EN defined: MULT and DIV use signed semantics (magnitude conversion plus FIX correction).
- Not defined: the op[0] bit is ignored, all ops are unsigned, and the FIX state still exists as a 1-cycle pass-through so latency is identical in both builds.

## Structure
- Shared package ex_pkg holds:
  - the op encoding localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - the state enum values
  - the default WIDTH
- One sub-module: muldiv_addsub, the WIDTH+1-bit add/subtract unit shared by both loops (inputs a, b, sub; outputs sum, carry). This is the only arithmetic resource.
- The FSM, counter, shift registers and FIX negation live in the top-level module.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF. Expect stall_req high on the start cycle, done in the 34th cycle after the start edge, hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT -7 × 3 (signed build). Expect hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. In the unsigned build, the same op gives hi = 0x00000002, lo = 0xFFFFFFEB.
- DIV -7 / 2. Expect lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIVU 100 / 7 gives lo = 14, hi = 2.
- DIVU 5 / 0. Expect done 1 cycle after start, div_by_zero = 1, hi = 5, lo = 0xFFFFFFFF. The next start clears div_by_zero.
- start pulsed again in CALC cycle 10. Expect it to be ignored: a single done pulse at the original time and the result of the first request.
- Reset driven low at CALC cycle 20. Expect IDLE next edge: busy, stall_req, done, hi, lo all 0, and no done pulse afterwards.
